// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration serial loader.
// Holds the per-pad word width, the loader state encoding and the power-on pad default.
package gpio_cfg_pkg;

    localparam int CFG_BITS = 13;

    localparam logic [CFG_BITS-1:0] GPIO_CFG_DEFAULT = 13'h1803;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Both chains are clocked together, so the transfer needs as many word slots as the longer chain.
    function automatic int word_slots(input int area1_pads, input int total_pads);
        int area2_pads;
        area2_pads = total_pads - area1_pads;
        return (area1_pads > area2_pads) ? area1_pads : area2_pads;
    endfunction

endpackage

// File: rtl/gpio_cfg_shifter.sv
// One CFG_BITS-wide MSB-first output shift register feeding a pad configuration chain.
// A capture either loads the fetched word or an all-zero filler word.
module gpio_cfg_shifter
    import gpio_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic                fill_zero,
    input  logic                shift_en,
    input  logic [CFG_BITS-1:0] data_in,
    output logic                serial_out
);

    logic [CFG_BITS-1:0] shreg_r;
    logic [CFG_BITS-1:0] shreg_s;

    // Next shift register value: capture, shift towards the MSB, or hold.
    always_comb begin
        shreg_s = shreg_r;
        if (load_en) begin
            if (fill_zero) begin
                shreg_s = {CFG_BITS{1'b0}};
            end else begin
                shreg_s = data_in;
            end
        end else if (shift_en) begin
            shreg_s = {shreg_r[CFG_BITS-2:0], 1'b0};
        end else begin
            shreg_s = shreg_r;
        end
    end

    // Shift register storage; zero fill-in means the output idles low once a word is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {CFG_BITS{1'b0}};
        end else begin
            shreg_r <= shreg_s;
        end
    end

    assign serial_out = shreg_r[CFG_BITS-1];

endmodule

// File: rtl/gpio_cfg_serial_loader.sv
// Streams one configuration word per user pad into the two pad control chains,
// then strobes the chains' parallel load.
module gpio_cfg_serial_loader
    import gpio_cfg_pkg::*;
#(
    parameter int AREA1PADS  = 19,
    parameter int TOTAL_PADS = 38,
    parameter int CLK_DIV    = 2
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          xfer_start,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(TOTAL_PADS)-1:0] cfg_addr_1,
    output logic [$clog2(TOTAL_PADS)-1:0] cfg_addr_2,
    input  logic [CFG_BITS-1:0]           cfg_data_1,
    input  logic [CFG_BITS-1:0]           cfg_data_2,
    output logic                          serial_clock,
    output logic                          serial_load,
    output logic                          serial_resetn,
    output logic                          serial_data_1,
    output logic                          serial_data_2
);

    localparam int AW    = $clog2(TOTAL_PADS);
    localparam int NW    = word_slots(AREA1PADS, TOTAL_PADS);
    localparam int FILL1 = NW - AREA1PADS;
    localparam int FILL2 = NW - (TOTAL_PADS - AREA1PADS);
    localparam int WW    = $clog2(NW + 1);
    localparam int BW    = $clog2(CFG_BITS);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [WW-1:0] WORD_LAST = WW'(NW - 1);
    localparam logic [BW-1:0] BIT_TOP   = BW'(CFG_BITS - 1);
    localparam logic [DW-1:0] DIV_TOP   = DW'(CLK_DIV - 1);

    state_e        state_r;
    state_e        state_s;
    logic [DW-1:0] div_r;
    logic [DW-1:0] div_s;
    logic          phase_r;
    logic          phase_s;
    logic [BW-1:0] bit_r;
    logic [BW-1:0] bit_s;
    logic [WW-1:0] word_r;
    logic [WW-1:0] word_s;
    logic          div_end_s;
    logic          capture_s;
    logic          shift_s;

    int            slot_s;
    logic [AW-1:0] addr_1_s;
    logic [AW-1:0] addr_2_s;
    logic          fill_1_s;
    logic          fill_2_s;

    logic          busy_r;
    logic          done_r;
    logic          sclk_r;
    logic          load_r;
    logic          resetn_r;
    logic [AW-1:0] addr_1_r;
    logic [AW-1:0] addr_2_r;

    // Next-state and counter logic; phase_r is the serial clock level in SHIFT and the
    // first/second cycle marker in FETCH and LOAD.
    always_comb begin
        state_s   = state_r;
        div_s     = div_r;
        phase_s   = phase_r;
        bit_s     = bit_r;
        word_s    = word_r;
        div_end_s = (div_r == DIV_TOP);
        capture_s = 1'b0;
        shift_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (xfer_start) begin
                    state_s = FETCH;
                    div_s   = {DW{1'b0}};
                    phase_s = 1'b0;
                    bit_s   = BIT_TOP;
                    word_s  = {WW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (phase_r) begin
                    capture_s = 1'b1;
                    phase_s   = 1'b0;
                    div_s     = {DW{1'b0}};
                    state_s   = SHIFT;
                end else begin
                    phase_s = 1'b1;
                end
            end
            SHIFT: begin
                if (div_end_s) begin
                    div_s = {DW{1'b0}};
                    if (!phase_r) begin
                        phase_s = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        shift_s = 1'b1;
                        if (bit_r == {BW{1'b0}}) begin
                            bit_s = BIT_TOP;
                            if (word_r == WORD_LAST) begin
                                state_s = LOAD;
                            end else begin
                                word_s  = word_r + WW'(1);
                                state_s = FETCH;
                            end
                        end else begin
                            bit_s = bit_r - BW'(1);
                        end
                    end
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            LOAD: begin
                if (div_end_s) begin
                    div_s = {DW{1'b0}};
                    if (phase_r) begin
                        phase_s = 1'b0;
                        state_s = DONE;
                    end else begin
                        phase_s = 1'b1;
                    end
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Chain 1 runs pads downward, chain 2 upward; the shorter chain's leading slots are filler.
    always_comb begin
        slot_s = int'(word_s);
        if (slot_s < FILL1) begin
            addr_1_s = {AW{1'b0}};
        end else begin
            addr_1_s = AW'(NW - 1 - slot_s);
        end
        if (slot_s < FILL2) begin
            addr_2_s = {AW{1'b0}};
        end else begin
            addr_2_s = AW'(AREA1PADS + slot_s - FILL2);
        end
        fill_1_s = (int'(word_r) < FILL1);
        fill_2_s = (int'(word_r) < FILL2);
    end

    // State, counters and registered outputs, all decoded from the next state.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r  <= IDLE;
            div_r    <= {DW{1'b0}};
            phase_r  <= 1'b0;
            bit_r    <= {BW{1'b0}};
            word_r   <= {WW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sclk_r   <= 1'b0;
            load_r   <= 1'b0;
            resetn_r <= 1'b0;
            addr_1_r <= {AW{1'b0}};
            addr_2_r <= {AW{1'b0}};
        end else begin
            state_r  <= state_s;
            div_r    <= div_s;
            phase_r  <= phase_s;
            bit_r    <= bit_s;
            word_r   <= word_s;
            busy_r   <= (state_s != IDLE);
            done_r   <= (state_s == DONE);
            sclk_r   <= (state_s == SHIFT) && phase_s;
            load_r   <= (state_s == LOAD);
            resetn_r <= 1'b1;
            if (state_s == FETCH) begin
                addr_1_r <= addr_1_s;
                addr_2_r <= addr_2_s;
            end
        end
    end

    gpio_cfg_shifter u_shift_1 (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .load_en    (capture_s),
        .fill_zero  (fill_1_s),
        .shift_en   (shift_s),
        .data_in    (cfg_data_1),
        .serial_out (serial_data_1)
    );

    gpio_cfg_shifter u_shift_2 (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .load_en    (capture_s),
        .fill_zero  (fill_2_s),
        .shift_en   (shift_s),
        .data_in    (cfg_data_2),
        .serial_out (serial_data_2)
    );

    assign busy          = busy_r;
    assign done          = done_r;
    assign serial_clock  = sclk_r;
    assign serial_load   = load_r;
    assign serial_resetn = resetn_r;
    assign cfg_addr_1    = addr_1_r;
    assign cfg_addr_2    = addr_2_r;

endmodule
